// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier batch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ACC_W  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_batch_ram.sv
// Register-array RAM: one write port, one read port (registered or combinational).
// Latency: write lands on the clock edge; read is 1 cycle (REG_RD=1) or 0 cycles (REG_RD=0).
// Backpressure: none, every access is accepted.
// Ports: clk/rst; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
// rst only clears the registered read output; array contents are never reset.
module mul_batch_ram #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int REG_RD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg
            logic [DW-1:0] r_rdata;
            // Reads the pre-write contents when the same address is written this cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= r_mem[i_raddr];
                end
            end
            assign o_rdata = r_rdata;
        end else begin : g_comb
            assign o_rdata = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/mul_batch_seq.sv
// Sequencer feeding stored operand pairs to an external multiplier and storing products.
// Latency: MUL_WAIT+2 cycles per pair; start..done inclusive = 1 + len_q*(MUL_WAIT+2) + 1.
// Backpressure: start and operand writes are ignored while busy; result reads always allowed.
// Ports: clk/rst; i_wr_* operand load; i_start/i_len launch; o_busy/o_done status;
//        o_mul_a/o_mul_b/i_mul_r multiplier link; i_rd_addr/o_rd_data result readback;
//        o_acc_out running product sum (only when MUL_BATCH_SEQ_ACCUM_EN is defined).
module mul_batch_seq
    import mul_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int MUL_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [OP_W-1:0]   i_wr_a,
    input  logic [OP_W-1:0]   i_wr_b,
    input  logic              i_start,
    input  logic [AW:0]       i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [OP_W-1:0]   o_mul_a,
    output logic [OP_W-1:0]   o_mul_b,
    input  logic [PROD_W-1:0] i_mul_r,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [PROD_W-1:0] o_rd_data
`ifdef MUL_BATCH_SEQ_ACCUM_EN
    ,
    output logic [ACC_W-1:0]  o_acc_out
`endif
);

    // Counter must hold MUL_WAIT-1 and stay at least one bit wide.
    localparam int CW = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [AW:0]         r_idx;
    logic [AW:0]         r_len_q;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [OP_W-1:0]     r_mul_a;
    logic [OP_W-1:0]     r_mul_b;

    logic                w_start_acc;
    logic [AW:0]         w_len_sat;
    logic                w_last;
    logic [2*OP_W-1:0]   w_op_dat;

    assign w_start_acc = (r_state == IDLE) && i_start;
    assign w_len_sat   = (i_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_len;
    // idx is one bit wider than the address so a full-depth batch can terminate.
    assign w_last      = (r_idx == (r_len_q - (AW+1)'(1)));

    // Operand RAM: {a,b} packed, read combinationally in ISSUE.
    mul_batch_ram #(.AW(AW), .DW(2*OP_W), .REG_RD(0)) u_op_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (i_wr_en && !r_busy),
        .i_waddr (i_wr_addr),
        .i_wdata ({i_wr_a, i_wr_b}),
        .i_raddr (r_idx[AW-1:0]),
        .o_rdata (w_op_dat)
    );

    // Result RAM: written in STORE, registered host read.
    mul_batch_ram #(.AW(AW), .DW(PROD_W), .REG_RD(1)) u_res_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (r_state == STORE),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (i_mul_r),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_acc) w_next = (w_len_sat == '0) ? FIN : ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = STORE;
            STORE:   w_next = w_last ? FIN : ISSUE;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_idx   <= '0;
            r_len_q <= '0;
            r_cnt   <= '0;
        end else begin
            // Status is registered from the next state so it lines up with the state itself;
            // busy therefore stays high through FIN and drops on the return to IDLE.
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == FIN);
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_len_q <= w_len_sat;
                        r_idx   <= '0;
                    end
                end
                ISSUE: begin
                    r_mul_a <= w_op_dat[2*OP_W-1:OP_W];
                    r_mul_b <= w_op_dat[OP_W-1:0];
                    r_cnt   <= CW'(MUL_WAIT - 1);
                end
                WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                STORE: begin
                    if (!w_last) r_idx <= r_idx + (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_BATCH_SEQ_ACCUM_EN
    logic [ACC_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_start_acc) begin
            r_acc <= '0;
        end else if (r_state == STORE) begin
            r_acc <= r_acc + ACC_W'(i_mul_r);
        end
    end

    assign o_acc_out = r_acc;
`endif

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_mul_a = r_mul_a;
    assign o_mul_b = r_mul_b;

endmodule

// File: tb/tb_mul_batch_seq.sv
// Self-checking bench for mul_batch_seq with an ideal 2-cycle multiplier model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_batch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_wr_en = 1'b0;
    logic [3:0] i_wr_addr = '0;
    logic [3:0] i_wr_a = '0;
    logic [3:0] i_wr_b = '0;
    logic       i_start = 1'b0;
    logic [4:0] i_len = '0;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_mul_a;
    logic [3:0] o_mul_b;
    logic [7:0] i_mul_r;
    logic [3:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
`ifdef MUL_BATCH_SEQ_ACCUM_EN
    logic [11:0] o_acc_out;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Ideal multiplier: product appears two clocks after the operands.
    logic [7:0] p1 = '0;
    logic [7:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= 8'(o_mul_a) * 8'(o_mul_b);
        p2 <= p1;
    end
    assign i_mul_r = p2;

    mul_batch_seq dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_a    (i_wr_a),
        .i_wr_b    (i_wr_b),
        .i_start   (i_start),
        .i_len     (i_len),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_mul_a   (o_mul_a),
        .o_mul_b   (o_mul_b),
        .i_mul_r   (i_mul_r),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
`ifdef MUL_BATCH_SEQ_ACCUM_EN
        ,
        .o_acc_out (o_acc_out)
`endif
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] r;
    } vec_t;

    vec_t vec[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr_op(input int addr, input int a, input int b);
        i_wr_en   = 1'b1;
        i_wr_addr = 4'(addr);
        i_wr_a    = 4'(a);
        i_wr_b    = 4'(b);
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [7:0] d);
        i_rd_addr = 4'(addr);
        tick();
        d = o_rd_data;
    endtask

    // Launches a batch and follows it to completion. lat counts the start cycle
    // and the done cycle inclusively. inj>0 drives a write to op[3] and a stray
    // start for one cycle at that cycle offset, both while busy.
    task automatic run_batch(input int len, input int inj,
                             output int lat, output int busy_cnt, output int done_cnt);
        int c;
        bit seen;
        i_start  = 1'b1;
        i_len    = 5'(len);
        tick();
        i_start  = 1'b0;
        c        = 1;
        seen     = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        done_cnt = 0;
        while (c < 400) begin
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                if (!seen) lat = c + 1;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            if (inj > 0 && c == inj) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 4'd3;
                i_wr_a    = 4'd15;
                i_wr_b    = 4'd15;
                i_start   = 1'b1;
                i_len     = 5'd1;
            end else if (inj > 0 && c == inj + 1) begin
                i_wr_en = 1'b0;
                i_start = 1'b0;
            end
            tick();
            c++;
        end
        chk("batch_completes", {31'd0, seen}, 32'd1);
        chk("busy_after_done", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int lat, bc, dc;
        logic [7:0] d;

        // Hand-computed (i, 15-i) products.
        vec[0]  = '{4'd0,  4'd15, 8'd0};
        vec[1]  = '{4'd1,  4'd14, 8'd14};
        vec[2]  = '{4'd2,  4'd13, 8'd26};
        vec[3]  = '{4'd3,  4'd12, 8'd36};
        vec[4]  = '{4'd4,  4'd11, 8'd44};
        vec[5]  = '{4'd5,  4'd10, 8'd50};
        vec[6]  = '{4'd6,  4'd9,  8'd54};
        vec[7]  = '{4'd7,  4'd8,  8'd56};
        vec[8]  = '{4'd8,  4'd7,  8'd56};
        vec[9]  = '{4'd9,  4'd6,  8'd54};
        vec[10] = '{4'd10, 4'd5,  8'd50};
        vec[11] = '{4'd11, 4'd4,  8'd44};
        vec[12] = '{4'd12, 4'd3,  8'd36};
        vec[13] = '{4'd13, 4'd2,  8'd26};
        vec[14] = '{4'd14, 4'd1,  8'd14};
        vec[15] = '{4'd15, 4'd0,  8'd0};

        // Reset state
        tick();
        tick();
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_done",  {31'd0, o_done}, 32'd0);
        chk("rst_mul_a", {28'd0, o_mul_a}, 32'd0);
        chk("rst_mul_b", {28'd0, o_mul_b}, 32'd0);
        chk("rst_rd",    {24'd0, o_rd_data}, 32'd0);
`ifdef MUL_BATCH_SEQ_ACCUM_EN
        chk("rst_acc",   {20'd0, o_acc_out}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Single pair
        wr_op(0, 3, 5);
        run_batch(1, 0, lat, bc, dc);
        chk("single_lat",  lat, 8);
        chk("single_busy", bc, 7);
        chk("single_done", dc, 1);
        rd(0, d);
        chk("single_res", {24'd0, d}, 15);

        // Full batch from the table
        for (int i = 0; i < 16; i++) wr_op(i, vec[i].a, vec[i].b);
        run_batch(16, 0, lat, bc, dc);
        chk("full_lat",  lat, 98);
        chk("full_busy", bc, 97);
        chk("full_done", dc, 1);
        for (int i = 0; i < 16; i++) begin
            rd(i, d);
            chk($sformatf("full_res[%0d]", i), {24'd0, d}, {24'd0, vec[i].r});
        end

        // Zero length
        run_batch(0, 0, lat, bc, dc);
        chk("len0_lat",  lat, 2);
        chk("len0_done", dc, 1);
        chk("len0_busy", bc, 1);
        rd(1, d);
        chk("len0_res1", {24'd0, d}, 14);

        // Oversize length saturates to DEPTH
        wr_op(15, 9, 9);
        run_batch(31, 0, lat, bc, dc);
        chk("len31_lat",  lat, 98);
        chk("len31_done", dc, 1);
        rd(15, d);
        chk("len31_res15", {24'd0, d}, 81);
        rd(0, d);
        chk("len31_res0", {24'd0, d}, 0);

        // Writes and start while busy are ignored
        wr_op(2, 2, 2);
        run_batch(4, 3, lat, bc, dc);
        chk("blk_lat",  lat, 26);
        chk("blk_done", dc, 1);
        rd(2, d);
        chk("blk_res2", {24'd0, d}, 4);
        rd(3, d);
        chk("blk_res3", {24'd0, d}, 36);

        // Reset during pair 3 of 8
        wr_op(0, 1, 1);
        wr_op(1, 2, 5);
        wr_op(2, 4, 4);
        wr_op(3, 5, 5);
        i_start = 1'b1;
        i_len   = 5'd8;
        tick();
        i_start = 1'b0;
        dc = 0;
        for (int c = 1; c < 20; c++) begin
            if (o_done) dc++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",  {31'd0, o_busy}, 32'd0);
        chk("abort_done",  {31'd0, o_done}, 32'd0);
        chk("abort_mul_a", {28'd0, o_mul_a}, 32'd0);
        chk("abort_mul_b", {28'd0, o_mul_b}, 32'd0);
        chk("abort_rd",    {24'd0, o_rd_data}, 32'd0);
        bc = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done) dc++;
            if (o_busy) bc++;
            tick();
        end
        chk("abort_no_done", dc, 0);
        chk("abort_idle",    bc, 0);
        rd(0, d);
        chk("abort_res0", {24'd0, d}, 1);
        rd(1, d);
        chk("abort_res1", {24'd0, d}, 10);
        rd(2, d);
        chk("abort_res2", {24'd0, d}, 16);
        rd(3, d);
        chk("abort_res3", {24'd0, d}, 36);

`ifdef MUL_BATCH_SEQ_ACCUM_EN
        // Accumulator: 16 x 225 = 3600, then cleared by the next start
        for (int i = 0; i < 16; i++) wr_op(i, 15, 15);
        run_batch(16, 0, lat, bc, dc);
        chk("acc_full", {20'd0, o_acc_out}, 3600);
        wr_op(0, 2, 3);
        run_batch(1, 0, lat, bc, dc);
        chk("acc_clear", {20'd0, o_acc_out}, 6);
        tick();
        chk("acc_hold", {20'd0, o_acc_out}, 6);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_batch_seq.md
Name: mul_batch_seq

Overview:
- Upstream sequencer for the 4-bit clocked multiplier stage.
- Host loads up to DEPTH operand pairs into an internal operand RAM, then pulses start.
- The block feeds each pair to the external multiplier, holds the operands stable for a fixed wait, captures the 8-bit product and writes it into an internal result RAM that the host can read back.
- It sits between the host/test harness and the multiplier; it contains no multiplier of its own.

Parameters:
- DEPTH, 16, number of operand/result entries.
- AW, 4, address width (DEPTH = 2**AW).
- MUL_WAIT, 4, cycles operands are held before the product is sampled; must be ≥ multiplier latency + phase slack, and ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write operand pair to the operand RAM.
- wr_addr  in  AW  operand RAM write address.
- wr_a  in  4  operand A to store.
- wr_b  in  4  operand B to store.
- start  in  1  launch a batch; sampled only in IDLE.
- len  in  AW+1  number of pairs in the batch; latched on start.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at the end of a batch.
- mul_a  out  4  operand A to the multiplier.
- mul_b  out  4  operand B to the multiplier.
- mul_r  in  8  product from the multiplier.
- rd_addr  in  AW  result RAM read address.
- rd_data  out  8  registered result read; 1-cycle latency.
- acc_out  out  12  running sum of products; present only with ACCUM_EN.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, mul_a 0, mul_b 0, rd_data 0, idx 0, acc_out 0. RAM contents are not reset.
- FSM states: IDLE, ISSUE, WAIT, STORE, FIN.
- IDLE:
  - start=1 latches len_q = min(len, DEPTH) and sets idx=0.
  - If len_q=0, go to FIN; otherwise go to ISSUE.
- ISSUE (1 cycle): mul_a/mul_b <= op RAM[idx]; wait counter <= MUL_WAIT-1; go to WAIT.
- WAIT (MUL_WAIT cycles):
  - Counter decrements each cycle; at 0, go to STORE.
  - mul_a/mul_b stay stable throughout.
- STORE (1 cycle):
  - res RAM[idx] <= mul_r.
  - If idx == len_q-1, go to FIN; otherwise idx++ and go to ISSUE.
- FIN: done=1 for exactly this cycle; busy drops; go to IDLE.
- Throughput: MUL_WAIT+2 cycles per pair. Batch latency from start to done = 1 + len_q*(MUL_WAIT+2) + 1 cycles.
- Operand RAM writes: accepted only when not busy; wr_en during busy is ignored with no side effect.
- start while busy: ignored.
- start and wr_en in the same IDLE cycle: the write lands first, and the batch sees the new value.
- Result RAM reads: allowed at any time. rd_data = res RAM[rd_addr] from the previous cycle. A read of the address being written in STORE returns the old value.
- Reset mid-batch: aborts immediately, no done pulse. Results already written remain in the result RAM.
- Arithmetic: idx is AW+1 bits internally, so len=DEPTH terminates correctly. len > DEPTH saturates to DEPTH.

Optional Feature:
- Macro: MUL_BATCH_SEQ_ACCUM_EN.
- Defined:
  - acc_out exists; it is cleared to 0 on the accepted start.
  - In each STORE cycle, acc_out += zero-extended mul_r (12 bits, wraps mod 4096).
  - acc_out holds its value after done.
- Undefined: no acc_out port and no accumulator logic.

Decomposition:
- Shared package mul_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT, STORE, FIN).
  - Width constants OP_W=4, PROD_W=8, ACC_W=12.
- One natural sub-module, mul_batch_ram: a dual-port register-array RAM with one write port and one registered read port. It is instantiated twice: the operand RAM (8-bit {a,b}, combinational read used by ISSUE) and the result RAM (8-bit, registered read).

Test Plan:
- Bench setup: an ideal behavioural multiplier model (r = A*B after 2 cycles).
- Single pair: write addr0 a=3, b=5; start len=1 → done 8 cycles after start (MUL_WAIT=4); read addr0 → 15; busy high 7 cycles.
- Full batch: write pairs (i, 15-i) for i=0..15; start len=16 → results 0,14,26,36,44,50,54,56,56,54,50,44,36,26,14,0; done exactly once.
- Zero/oversize len:
  - len=0 → done 2 cycles after start, no result writes.
  - len=31 → behaves as len=16.
- Blocked activity while busy: start and wr_en during busy → ignored; operand RAM unchanged; batch completes normally.
- Reset mid-batch: pulse rst during pair 3 of 8 → no done; busy 0; pairs 0-2 results readable; outputs at reset values.
- Accumulator (MUL_BATCH_SEQ_ACCUM_EN): pairs (15,15)×16 → acc_out = 3600. A second batch (2,3)×1 → acc_out = 6 (cleared on start).
